// File: rtl/id_ex_if.sv
// ID->EX stage bundle: decoder outputs and hazard inputs from ID/EX/MEM, latched EX entry back out.
// master = the pipeline around the register, slave = the id_ex_stage register itself.
interface id_ex_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [13:0]      id_ctrl;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [3:0]       id_funct;
  logic             ex_flush;
  logic             mem_hold;

  logic             stall_o;
  logic             ex_valid;
  logic [11:0]      ex_ctrl;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [3:0]       ex_funct;
  logic [CNT_W-1:0] bubble_cnt;

  // There is no valid/ready pair here: id_valid qualifies the ID entry,
  // stall_o tells IF/ID to re-present the same entry next cycle, and
  // mem_hold freezes the whole register regardless of anything else.
  modport master (
    output id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct, ex_flush, mem_hold,
    input  stall_o, ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, bubble_cnt
  );

  modport slave (
    input  id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct, ex_flush, mem_hold,
    output stall_o, ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, EX flush, memory hold
// and a saturating bubble counter for performance debug.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  id_ex_if.slave bus
);

  // Bit positions inside the 12-bit EX control bundle (id_ctrl[13:2]).
  localparam int EX_MEMREAD  = 10;
  localparam int EX_REGWRITE = 5;
  localparam int ID_USE_RS1  = 1;
  localparam int ID_USE_RS2  = 0;

  logic             valid_q;
  logic [11:0]      ctrl_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  rs1_data_q;
  logic [XLEN-1:0]  rs2_data_q;
  logic [XLEN-1:0]  imm_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [4:0]       rd_q;
  logic [3:0]       funct_q;
  logic [CNT_W-1:0] cnt_q;

  logic [11:0]      ctrl_clean;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             load_use;
  logic             take;
  logic             count_evt;
  logic             cnt_sat;

  // Only a definite 1 survives; decoder don't-cares land in EX as 0.
  always_comb begin
    ctrl_clean = '0;
    for (int i = 0; i < 12; i++) begin
      ctrl_clean[i] = (bus.id_ctrl[i+2] === 1'b1);
    end
  end

  always_comb begin
    rs1_hit   = bus.id_ctrl[ID_USE_RS1] & (bus.id_rs1 == rd_q);
    rs2_hit   = bus.id_ctrl[ID_USE_RS2] & (bus.id_rs2 == rd_q);
    load_use  = valid_q & ctrl_q[EX_MEMREAD] & ctrl_q[EX_REGWRITE] &
                (rd_q != 5'd0) & bus.id_valid & (rs1_hit | rs2_hit);
    take      = bus.id_valid & ~bus.ex_flush & ~load_use;
    count_evt = bus.ex_flush | load_use;
    cnt_sat   = &cnt_q;
  end

  // A flush wins over load-use: the dependent instruction is dead anyway.
  assign bus.stall_o = rst_n & (bus.mem_hold | (load_use & ~bus.ex_flush));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      cnt_q      <= '0;
    end else if (!bus.mem_hold) begin
      // Data fields follow ID even on a bubble; ex_valid/ex_ctrl gate their use.
      pc_q       <= bus.id_pc;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
      rs1_q      <= bus.id_rs1;
      rs2_q      <= bus.id_rs2;
      rd_q       <= bus.id_rd;
      funct_q    <= bus.id_funct;
      valid_q    <= take;
      ctrl_q     <= take ? ctrl_clean : 12'd0;
      if (count_evt && !cnt_sat) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_ctrl     = ctrl_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_rs1_data = rs1_data_q;
  assign bus.ex_rs2_data = rs2_data_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs1      = rs1_q;
  assign bus.ex_rs2      = rs2_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_funct    = funct_q;
  assign bus.bubble_cnt  = cnt_q;

endmodule
